// File: rtl/spi_pixel_pkg.sv
// Shared types and command codes for the SPI pixel receiver.
package spi_pixel_pkg;

    // Receiver frame state
    typedef enum logic [2:0] {
        IDLE,
        CMD,
        IMG_TOT,
        PIX,
        DISCARD
    } rx_state_t;

    // Default command bytes sent by the R-Pi as the first byte of a frame
    localparam logic [7:0] CMD_IMG_TOT_DEFAULT = 8'h01;
    localparam logic [7:0] CMD_PIXELS_DEFAULT  = 8'h02;

    // One pixel as {R,G,B}
    typedef logic [23:0] pixel_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser and registered edge detection for the oversampled SPI pins.
// All outputs are single-cycle pulses (or levels for mosi_s) aligned so that
// mosi_s is the data value seen at the SCLK edge reported in the same cycle.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iCLK_50,
    input  logic iRST_N,
    input  logic iSCLK,
    input  logic iCS_N,
    input  logic iMOSI,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;
    logic                   sclk_rise_q;
    logic                   sclk_fall_q;
    logic                   cs_rise_q;
    logic                   cs_fall_q;
    logic                   mosi_q;
    logic                   sclk_s;
    logic                   cs_s;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    // Synchroniser chains followed by one edge-detect register stage
    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            // NOTE: chip select resets to its idle (high) level so that reset
            // release never looks like a CS_N fall or rise.
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage capture the
            // previous stage's old value, which is what forms the chain.
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], iSCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], iCS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], iMOSI};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            sclk_rise_q <= sclk_s & ~sclk_prev_q;
            sclk_fall_q <= ~sclk_s & sclk_prev_q;
            cs_rise_q   <= cs_s & ~cs_prev_q;
            cs_fall_q   <= ~cs_s & cs_prev_q;
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_rise_q;
    assign sclk_fall = sclk_fall_q;
    assign cs_rise   = cs_rise_q;
    assign cs_fall   = cs_fall_q;
    assign mosi_s    = mosi_q;

endmodule

// File: rtl/spi_pixel_rx.sv
// SPI slave (mode 0) receiving command frames from the R-Pi and producing a
// pixel stream with a one-cycle strobe, plus the total image count.
module spi_pixel_rx
    import spi_pixel_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_IMG_TOT = CMD_IMG_TOT_DEFAULT,
    parameter logic [7:0] CMD_PIXELS  = CMD_PIXELS_DEFAULT
) (
    input  logic        iCLK_50,
    input  logic        iRST_N,
    input  logic        iSCLK,
    input  logic        iCS_N,
    input  logic        iMOSI,
    output logic        oMISO,
    input  logic        iImage_Loaded,
    output logic [23:0] oPix_Data,
    output logic        oTrigger,
    output logic [7:0]  oImg_Tot,
    output logic        oFrame_Err
);

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic mosi_s;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .iCLK_50   (iCLK_50),
        .iRST_N    (iRST_N),
        .iSCLK     (iSCLK),
        .iCS_N     (iCS_N),
        .iMOSI     (iMOSI),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .mosi_s    (mosi_s)
    );

    rx_state_t  state_q;
    logic [2:0] bit_cnt_q;
    logic [1:0] byte_idx_q;
    logic [7:0] rx_sr_q;
    logic [7:0] miso_sr_q;
    logic       miso_q;
    logic [7:0] red_q;
    logic [7:0] green_q;
    pixel_t     pix_q;
    logic       trig_q;
    logic [7:0] img_tot_q;
    logic       err_q;

    logic [7:0] rx_byte_d;
    logic [2:0] bit_cnt_d;
    logic       byte_done;

    // Byte being assembled including the bit sampled this cycle
    assign rx_byte_d = {rx_sr_q[6:0], mosi_s};
    assign bit_cnt_d = bit_cnt_q + 3'd1;
    assign byte_done = (bit_cnt_q == 3'd7);

    // Frame FSM with bit/byte counters, shift registers and output registers
    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            rx_sr_q    <= '0;
            miso_sr_q  <= '0;
            miso_q     <= 1'b0;
            red_q      <= '0;
            green_q    <= '0;
            pix_q      <= '0;
            trig_q     <= 1'b0;
            img_tot_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            if (cs_rise) begin
                // End of frame wins over any SCLK edge in the same cycle;
                // a pixel cut short is reported, partial state is dropped.
                if (state_q == PIX && (byte_idx_q != 2'd0 || bit_cnt_q != 3'd0)) begin
                    err_q <= 1'b1;
                end
                state_q    <= IDLE;
                bit_cnt_q  <= '0;
                byte_idx_q <= '0;
                rx_sr_q    <= '0;
                miso_q     <= 1'b0;
            end else begin
                // Status byte is shifted out only while the command byte is in flight
                if (sclk_fall) begin
                    if (state_q == CMD) begin
                        miso_q    <= miso_sr_q[6];
                        miso_sr_q <= {miso_sr_q[6:0], 1'b0};
                    end else begin
                        miso_q <= 1'b0;
                    end
                end

                case (state_q)
                    IDLE: begin
                        if (cs_fall) begin
                            state_q    <= CMD;
                            bit_cnt_q  <= '0;
                            byte_idx_q <= '0;
                            miso_sr_q  <= {7'b0, iImage_Loaded};
                        end
                    end
                    default: begin
                        if (sclk_rise) begin
                            rx_sr_q   <= rx_byte_d;
                            bit_cnt_q <= bit_cnt_d;
                            if (byte_done) begin
                                case (state_q)
                                    CMD: begin
                                        if (rx_byte_d == CMD_IMG_TOT) begin
                                            state_q <= IMG_TOT;
                                        end else if (rx_byte_d == CMD_PIXELS) begin
                                            state_q    <= PIX;
                                            byte_idx_q <= '0;
                                        end else begin
                                            state_q <= DISCARD;
                                            err_q   <= 1'b1;
                                        end
                                    end
                                    IMG_TOT: begin
                                        img_tot_q <= rx_byte_d;
                                        state_q   <= DISCARD;
                                    end
                                    PIX: begin
                                        case (byte_idx_q)
                                            2'd0: begin
                                                red_q      <= rx_byte_d;
                                                byte_idx_q <= 2'd1;
                                            end
                                            2'd1: begin
                                                green_q    <= rx_byte_d;
                                                byte_idx_q <= 2'd2;
                                            end
                                            default: begin
                                                pix_q      <= {red_q, green_q, rx_byte_d};
                                                trig_q     <= 1'b1;
                                                byte_idx_q <= 2'd0;
                                            end
                                        endcase
                                    end
                                    default: begin
                                        // DISCARD: bytes are counted but ignored
                                    end
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign oMISO      = miso_q;
    assign oPix_Data  = pix_q;
    assign oTrigger   = trig_q;
    assign oImg_Tot   = img_tot_q;
    assign oFrame_Err = err_q;

endmodule
